// File: rtl/ifetch.sv
// Instruction fetch stage: drives the pc step/load pulses, runs the instruction
// memory request/ack handshake and holds one fetched word for decode.
module ifetch #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] pc_counter,
  output logic                 pc_offset,
  output logic                 pc_load,
  output logic [WORD_SIZE-1:0] pc_data,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  input  logic                 stall,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 instr_valid
);

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_FETCH    = 3'd1,
    S_ADVANCE  = 3'd2,
    S_FULL     = 3'd3,
    S_DRAIN    = 3'd4,
    S_REDIRECT = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [WORD_SIZE-1:0] target_q, target_d;
  logic                 pc_offset_q, pc_offset_d;
  logic                 pc_load_q, pc_load_d;
  logic [WORD_SIZE-1:0] pc_data_q, pc_data_d;
  logic                 mem_req_q, mem_req_d;
  logic                 consume_c;

  assign consume_c = instr_valid_q && !stall;

  // Next state and IR update; redirect overrides both consume and ack.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    target_d      = target_q;

    if (consume_c) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          instr_d       = mem_rdata;
          instr_pc_d    = pc_counter;
          instr_valid_d = 1'b1;
          state_d       = S_ADVANCE;
        end
      end
      S_ADVANCE: state_d = consume_c ? S_FETCH : S_FULL;
      S_FULL: begin
        if (consume_c) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: state_d = S_FETCH;
      default:    state_d = S_START;
    endcase

    // An outstanding request is never aborted, so an unacked fetch drains first.
    if (redirect) begin
      target_d      = redirect_target;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      if ((state_q == S_FETCH || state_q == S_DRAIN) && !mem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REDIRECT;
      end
    end
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    mem_req_d   = (state_d == S_FETCH) || (state_d == S_DRAIN);
    pc_offset_d = (state_d == S_ADVANCE);
    pc_load_d   = (state_d == S_REDIRECT);
    pc_data_d   = '0;
    if (state_d == S_ADVANCE) begin
      pc_data_d = WORD_SIZE'(1);
    end else if (state_d == S_REDIRECT) begin
      pc_data_d = target_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_START;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      target_q      <= '0;
      pc_offset_q   <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_data_q     <= '0;
      mem_req_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      target_q      <= target_d;
      pc_offset_q   <= pc_offset_d;
      pc_load_q     <= pc_load_d;
      pc_data_q     <= pc_data_d;
      mem_req_q     <= mem_req_d;
    end
  end

  assign pc_offset   = pc_offset_q;
  assign pc_load     = pc_load_q;
  assign pc_data     = pc_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_counter;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage sitting directly downstream of the `pc` block. It reads the current `pc_counter`, runs a request/acknowledge read against instruction memory, and holds the returned word in a single-entry instruction register for decode. It also drives `pc`'s `offset`, `load_pc` and `data_in` inputs, either to step the PC by 1 or to load a branch/jump target supplied by execute.

## Interface
- `WORD_SIZE`, 32, width of instructions and word addresses.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_counter`  in  WORD_SIZE  current PC from `pc`, as a word address.
- `pc_offset`  out  1  to `pc.offset`; step-PC pulse.
- `pc_load`  out  1  to `pc.load_pc`; load-target pulse.
- `pc_data`  out  WORD_SIZE  to `pc.data_in`; 1 during a step, the target during a load, 0 otherwise.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  WORD_SIZE  read address; equals `pc_counter` while `mem_req`=1.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WORD_SIZE  instruction word.
- `redirect`  in  1  branch/jump taken (one-cycle pulse from execute).
- `redirect_target`  in  WORD_SIZE  new PC; sampled while `redirect`=1.
- `stall`  in  1  decode not ready.
- `instr`  out  WORD_SIZE  instruction register.
- `instr_pc`  out  WORD_SIZE  address that `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.

## Operation
- All outputs are registered. The only exception is `mem_addr`, which is driven combinationally from `pc_counter`.
- States:
  - START: outputs idle; next state FETCH.
  - FETCH: `mem_req`=1 and `mem_addr`=`pc_counter`.
    - On `mem_ack`: `instr`←`mem_rdata`, `instr_pc`←`pc_counter`, `instr_valid`←1, then go to ADVANCE.
  - ADVANCE: `pc_offset`=1 and `pc_data`=1 for exactly this cycle.
    - If the instruction is consumed this cycle, go to FETCH; otherwise go to FULL.
  - FULL: wait for consume.
    - On consume: `instr_valid`←0 and go to FETCH.
  - DRAIN: `mem_req` is held with the old address; the returned data is discarded.
    - On `mem_ack`, go to REDIRECT.
  - REDIRECT: `pc_load`=1 and `pc_data`=pending target for this cycle; next state FETCH.
- Consume means `instr_valid`=1 && `stall`=0 in a cycle. When a consume happens, `instr_valid` clears on the next edge unless a new instruction is loaded on that same edge.
- No new fetch starts while the IR is full. Single-entry buffer: at most one instruction is in flight or held at a time.
- Once `mem_req` is raised, it stays high and `mem_addr` stays stable until `mem_ack`. A request is never aborted.
- Redirect has priority over consume and over ack:
  - Pending target ← `redirect_target`, and `instr_valid`←0.
  - In FETCH without `mem_ack`, go to DRAIN.
  - In any other state, including FETCH with `mem_ack` (data discarded), go to REDIRECT.
  - A redirect arriving during DRAIN or REDIRECT overwrites the pending target, so the last target wins. REDIRECT then repeats for one more cycle with the new target.
- Redirect in ADVANCE: the step pulse has already been issued, and the following REDIRECT load overrides it.
- Arithmetic: none beyond pass-through. PC wrap-around (all-ones + 1 → 0) belongs to `pc`; this block fetches whatever address `pc_counter` presents.

## Timing
- Reset: state START. `instr`, `instr_pc`, `pc_data` = 0; `instr_valid`, `pc_offset`, `pc_load`, `mem_req` = 0. Applies on any cycle, including mid-request. The memory must tolerate `mem_req` dropping on reset.
- First `mem_req` is asserted 1 cycle after `rst` deasserts (START cycle, then FETCH), with `mem_addr`=0.
- Zero-wait memory (`mem_ack` in the first FETCH cycle) with `stall`=0:
  - `instr_valid` rises 1 cycle after ack.
  - One instruction every 2 cycles (FETCH, ADVANCE).
  - Successive `mem_addr` values 0, 1, 2, …
- Memory with N wait cycles: N+2 cycles per instruction.
- Redirect asserted in cycle t:
  - From FULL/ADVANCE: `pc_load` is high in cycle t+1, and FETCH with `mem_addr`=target is in cycle t+2.
  - From FETCH without ack: REDIRECT follows the cycle after the ack.
- `pc_offset` and `pc_load` are never high in the same cycle. Each is a single-cycle pulse per event.

## Test plan
- Reset, zero-wait memory returning `mem_rdata`=0x1000+addr, `stall`=0 → `mem_addr` runs 0,1,2,3; `instr` is 0x1000..0x1003 with matching `instr_pc`; exactly one `pc_offset` pulse per fetch.
- Memory acks 3 cycles after request → `mem_req` high for 4 cycles with `mem_addr` stable; the instruction is captured only on ack.
- `stall`=1 for 5 cycles after the first instruction → `instr_valid`, `instr` and `instr_pc` held; no `mem_req`; one `pc_offset` pulse total; fetch resumes the cycle after `stall` falls.
- `redirect` with target 0x40 while in FULL → `instr_valid` is 0 next cycle; `pc_load`=1 with `pc_data`=0x40 for one cycle; next `mem_addr`=0x40.
- `redirect` to 0x80 one cycle into a 3-cycle memory wait → `mem_req` held until ack; the returned data is never flagged valid; then `pc_load` to 0x80; a back-to-back second redirect to 0x90 during DRAIN → the load uses 0x90.
- `rst` pulsed during a memory wait → all outputs 0 on the next cycle; fetch restarts at address 0.
